uart_block_framer: RTL and testbench

Byte-to-block framing controller between the UART byte interface and a block-cipher core. It collects BLOCK_BYTES received bytes into one block, presents the block to the cipher over a valid/ready handshake, and captures the cipher result. It then serialises the result back out to the UART transmitter byte by byte. It replaces the ad-hoc byte counter and direct rx-to-tx echo in the top level, and adds configurable block size, configurable byte order, partial-block timeout and overrun reporting.

---
 rtl/uart_block_framer_if.sv | 45 ++++
 rtl/uart_block_framer.sv | 172 +++++++++++++++++
 tb/tb_uart_block_framer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_block_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_block_framer_if
//  Purpose  : Groups every handshake/data signal of uart_block_framer: the
//             UART receive strobe, the block and result valid/ready channels
//             to the cipher core, the UART transmit load/ready channel and
//             the status outputs.
//  Modports : master - the framer (drives block, result ready, tx, status)
//             slave  - the surrounding system (UART rx/tx and cipher core)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_block_framer_if #(
  parameter int BLOCK_BYTES = 16
) ();
  localparam int c_blockW = 8 * BLOCK_BYTES;
  localparam int c_countW = $clog2(BLOCK_BYTES + 1);

  logic [7:0]          rxDataIN;
  logic                rxValidIN;
  logic [c_blockW-1:0] blockOUT;
  logic                blockValidOUT;
  logic                blockReadyIN;
  logic [c_blockW-1:0] resultIN;
  logic                resultValidIN;
  logic                resultReadyOUT;
  logic [7:0]          txDataOUT;
  logic                txLoadOUT;
  logic                txReadyIN;
  logic [c_countW-1:0] byteCountOUT;
  logic                overrunOUT;
  logic                timeoutOUT;

  modport master (
    input  rxDataIN, rxValidIN, blockReadyIN, resultIN, resultValidIN, txReadyIN,
    output blockOUT, blockValidOUT, resultReadyOUT, txDataOUT, txLoadOUT,
           byteCountOUT, overrunOUT, timeoutOUT
  );

  modport slave (
    output rxDataIN, rxValidIN, blockReadyIN, resultIN, resultValidIN, txReadyIN,
    input  blockOUT, blockValidOUT, resultReadyOUT, txDataOUT, txLoadOUT,
           byteCountOUT, overrunOUT, timeoutOUT
  );
endinterface
`default_nettype wire

// File: rtl/uart_block_framer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_block_framer
//  Purpose  : Collects BLOCK_BYTES UART bytes into one block, hands the block
//             to a cipher core (valid/ready), captures the cipher result and
//             serialises it back to the UART transmitter byte by byte.
//             Drops and flags bytes received while busy, and optionally
//             discards a partial block after TIMEOUT_CYCLES idle cycles.
//  Ports    : clockIN   - single clock
//             nResetIN  - asynchronous active-low reset
//             bus       - uart_block_framer_if.master (rx bytes, block to
//                         cipher, result from cipher, tx bytes, status)
//  Params   : BLOCK_BYTES (>= 2), MSB_FIRST (1: first wire byte is the block
//             MSB byte), TIMEOUT_CYCLES (0 disables the partial timeout)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_block_framer #(
  parameter int BLOCK_BYTES    = 16,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  wire logic         clockIN,
  input  wire logic         nResetIN,
  uart_block_framer_if.master bus
);

  localparam int c_blockW = 8 * BLOCK_BYTES;
  localparam int c_countW = $clog2(BLOCK_BYTES + 1);
  localparam int c_idxW   = $clog2(BLOCK_BYTES);
  // Bit position of a slot is slot*8, so it needs exactly three more bits.
  localparam int c_posW   = c_idxW + 3;

  localparam logic [c_countW-1:0] c_lastCount = c_countW'(BLOCK_BYTES - 1);
  localparam logic [c_idxW-1:0]   c_lastIdx   = c_idxW'(BLOCK_BYTES - 1);
  localparam logic [c_posW-1:0]   c_topLsb    = c_posW'(c_blockW - 8);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    SEND     = 2'd3
  } stateT;

  stateT               r_state;
  stateT               w_nextState;
  logic [c_blockW-1:0] r_block;
  logic [c_blockW-1:0] r_result;
  logic [c_countW-1:0] r_byteCount;
  logic [c_idxW-1:0]   r_sendIdx;
  logic [7:0]          r_txData;
  logic                r_blockValid;
  logic                r_resultReady;
  logic                r_txLoad;
  logic                r_overrun;
  logic                r_timeoutPulse;

  logic w_rxAccept;
  logic w_lastRx;
  logic w_blockHs;
  logic w_resultHs;
  logic w_txHs;
  logic w_lastTx;
  logic w_timeoutFire;

  // Lowest bit of byte slot k: the same wire order is used for rx and tx.
  function automatic logic [c_posW-1:0] slotLsb(input logic [c_idxW-1:0] slot);
    if (MSB_FIRST != 0) return c_topLsb - {slot, 3'b000};
    else                return {slot, 3'b000};
  endfunction

  assign w_rxAccept = (r_state == COLLECT) && bus.rxValidIN;
  assign w_lastRx   = w_rxAccept && (r_byteCount == c_lastCount);
  assign w_blockHs  = r_blockValid && bus.blockReadyIN;
  assign w_resultHs = r_resultReady && bus.resultValidIN;
  assign w_txHs     = r_txLoad && bus.txReadyIN;
  assign w_lastTx   = w_txHs && (r_sendIdx == c_lastIdx);

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) r_state <= COLLECT;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      COLLECT:  if (w_lastRx)   w_nextState = ISSUE;
      ISSUE:    if (w_blockHs)  w_nextState = WAIT_RES;
      WAIT_RES: if (w_resultHs) w_nextState = SEND;
      SEND:     if (w_lastTx)   w_nextState = COLLECT;
      default:                  w_nextState = COLLECT;
    endcase
  end

  // Handshake outputs are registered copies of the next state, so each one
  // is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      r_block        <= '0;
      r_result       <= '0;
      r_byteCount    <= '0;
      r_sendIdx      <= '0;
      r_txData       <= 8'h00;
      r_blockValid   <= 1'b0;
      r_resultReady  <= 1'b0;
      r_txLoad       <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeoutPulse <= 1'b0;
    end else begin
      r_blockValid   <= (w_nextState == ISSUE);
      r_resultReady  <= (w_nextState == WAIT_RES);
      r_txLoad       <= (w_nextState == SEND);
      r_timeoutPulse <= w_timeoutFire;

      if (w_rxAccept) begin
        r_block[slotLsb(r_byteCount[c_idxW-1:0]) +: 8] <= bus.rxDataIN;
        r_byteCount <= w_lastRx ? '0 : r_byteCount + 1'b1;
      end else if (w_timeoutFire) begin
        r_byteCount <= '0;
      end

      if (bus.rxValidIN && (r_state != COLLECT)) r_overrun <= 1'b1;

      // txData is only updated on capture or on an accepted byte, so it
      // stays stable while the transmitter stalls.
      if (w_resultHs) begin
        r_result  <= bus.resultIN;
        r_sendIdx <= '0;
        r_txData  <= bus.resultIN[slotLsb({c_idxW{1'b0}}) +: 8];
      end else if (w_lastTx) begin
        r_sendIdx <= '0;
      end else if (w_txHs) begin
        r_sendIdx <= r_sendIdx + 1'b1;
        r_txData  <= r_result[slotLsb(r_sendIdx + 1'b1) +: 8];
      end
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int                c_idleW    = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [c_idleW-1:0] c_idleLast = c_idleW'(TIMEOUT_CYCLES - 1);
      localparam logic [c_idleW-1:0] c_idleMax  = c_idleW'(TIMEOUT_CYCLES);

      logic [c_idleW-1:0] r_idle;
      logic               w_running;

      assign w_running = (r_state == COLLECT) && (r_byteCount != '0);
      // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES; a
      // byte arriving in that cycle wins and restarts the count instead.
      assign w_timeoutFire = w_running && !bus.rxValidIN && (r_idle == c_idleLast);

      always_ff @(posedge clockIN or negedge nResetIN) begin
        if (!nResetIN)                            r_idle <= '0;
        else if (bus.rxValidIN)                   r_idle <= '0;
        else if (w_running && r_idle != c_idleMax) r_idle <= r_idle + 1'b1;
      end
    end else begin : g_noTimeout
      assign w_timeoutFire = 1'b0;
    end
  endgenerate

  assign bus.blockOUT       = r_block;
  assign bus.blockValidOUT  = r_blockValid;
  assign bus.resultReadyOUT = r_resultReady;
  assign bus.txDataOUT      = r_txData;
  assign bus.txLoadOUT      = r_txLoad;
  assign bus.byteCountOUT   = r_byteCount;
  assign bus.overrunOUT     = r_overrun;
  assign bus.timeoutOUT     = r_timeoutPulse;

endmodule
`default_nettype wire

// File: tb/tb_uart_block_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_block_framer
//  Purpose  : Self-checking bench for uart_block_framer. Instance A: 16-byte
//             blocks, MSB first, 20-cycle timeout. Instance B: 4-byte blocks,
//             LSB first, no timeout. A select flag routes the shared stimulus
//             to one instance and its outputs to the checks. Expected blocks
//             and tx bytes come from a byte-list model of the wire order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_block_framer;

  localparam int c_bytesA = 16;
  localparam int c_bytesB = 4;

  typedef logic [7:0] q8T[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nReset = 1'b0;
  logic         sel = 1'b0;
  logic [7:0]   rxData = 8'h00;
  logic         rxValid = 1'b0;
  logic         blockReady = 1'b0;
  logic [127:0] resultVec = '0;
  logic         resultValid = 1'b0;
  logic         txReady = 1'b0;
  logic         expOverrun = 1'b0;

  uart_block_framer_if #(.BLOCK_BYTES(c_bytesA)) ifA ();
  uart_block_framer_if #(.BLOCK_BYTES(c_bytesB)) ifB ();

  uart_block_framer #(.BLOCK_BYTES(c_bytesA), .MSB_FIRST(1), .TIMEOUT_CYCLES(20)) dutA (
    .clockIN(clk), .nResetIN(nReset), .bus(ifA)
  );
  uart_block_framer #(.BLOCK_BYTES(c_bytesB), .MSB_FIRST(0), .TIMEOUT_CYCLES(0)) dutB (
    .clockIN(clk), .nResetIN(nReset), .bus(ifB)
  );

  assign ifA.rxDataIN      = rxData;
  assign ifA.rxValidIN     = rxValid & ~sel;
  assign ifA.blockReadyIN  = blockReady & ~sel;
  assign ifA.resultIN      = resultVec;
  assign ifA.resultValidIN = resultValid & ~sel;
  assign ifA.txReadyIN     = txReady & ~sel;
  assign ifB.rxDataIN      = rxData;
  assign ifB.rxValidIN     = rxValid & sel;
  assign ifB.blockReadyIN  = blockReady & sel;
  assign ifB.resultIN      = resultVec[31:0];
  assign ifB.resultValidIN = resultValid & sel;
  assign ifB.txReadyIN     = txReady & sel;

  logic [127:0] blockOut;
  logic         blockValid, resultReady, txLoad, overrunFlag, timeoutPulse;
  logic [7:0]   txData;
  logic [4:0]   byteCount;
  assign blockOut     = sel ? {96'b0, ifB.blockOUT} : ifA.blockOUT;
  assign blockValid   = sel ? ifB.blockValidOUT  : ifA.blockValidOUT;
  assign resultReady  = sel ? ifB.resultReadyOUT : ifA.resultReadyOUT;
  assign txLoad       = sel ? ifB.txLoadOUT      : ifA.txLoadOUT;
  assign txData       = sel ? ifB.txDataOUT      : ifA.txDataOUT;
  assign byteCount    = sel ? {2'b0, ifB.byteCountOUT} : ifA.byteCountOUT;
  assign overrunFlag  = sel ? ifB.overrunOUT     : ifA.overrunOUT;
  assign timeoutPulse = sel ? ifB.timeoutOUT     : ifA.timeoutOUT;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s (inst %s): observed %0h, expected %0h", tag, sel ? "B" : "A", obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wire-order model: byte k of the list is the k-th byte on the wire.
  function automatic logic [127:0] pack(input q8T q, input bit msb);
    logic [127:0] v = '0;
    for (int k = 0; k < q.size(); k++) begin
      if (msb) v = (v << 8) | 128'(q[k]);
      else     v = v | (128'(q[k]) << (8 * k));
    end
    return v;
  endfunction

  function automatic q8T randBlock(input int n);
    q8T q = {};
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic checkResetValues(input string tag);
    check({tag, " blockOUT"},       blockOut, '0);
    check({tag, " blockValidOUT"},  blockValid, 1'b0);
    check({tag, " resultReadyOUT"}, resultReady, 1'b0);
    check({tag, " txDataOUT"},      txData, 8'h00);
    check({tag, " txLoadOUT"},      txLoad, 1'b0);
    check({tag, " byteCountOUT"},   byteCount, 5'd0);
    check({tag, " overrunOUT"},     overrunFlag, 1'b0);
    check({tag, " timeoutOUT"},     timeoutPulse, 1'b0);
  endtask

  task automatic doReset();
    rxValid = 1'b0; blockReady = 1'b0; resultValid = 1'b0; txReady = 1'b0;
    #2 nReset = 1'b0;
    #1 checkResetValues("async reset");
    expOverrun = 1'b0;
    tick(); tick();
    nReset = 1'b1;
    tick();
    check("post-reset byteCountOUT", byteCount, 5'd0);
  endtask

  task automatic sendBytes(input q8T data, input int first, input int last);
    int n = sel ? c_bytesB : c_bytesA;
    for (int k = first; k < last; k++) begin
      rxValid = 1'b1;
      rxData  = data[k];
      tick();
      check("byteCountOUT", byteCount, (k + 1 == n) ? 0 : k + 1);
      check("blockValidOUT", blockValid, (k + 1 == n));
      check("timeoutOUT quiet", timeoutPulse, 1'b0);
    end
    rxValid = 1'b0;
  endtask

  // One full transaction; bytes [0:first) of data must already be collected.
  task automatic runBlock(input q8T data, input int first, input int readyDelay,
                          input bit overrun, input int cipherLat, input int txMode,
                          input logic [7:0] key, input int abortAt);
    int n;
    bit msb, rdy;
    int idx, cyc;
    logic [127:0] expBlock, expResult;
    q8T rb;
    n   = sel ? c_bytesB : c_bytesA;
    msb = !sel;
    expBlock = pack(data, msb);
    rb = {};
    foreach (data[k]) rb.push_back(data[k] ^ key);
    expResult = pack(rb, msb);

    sendBytes(data, first, n);
    check("blockValidOUT rise", blockValid, 1'b1);
    check("blockOUT", blockOut, expBlock);

    for (int i = 0; i < readyDelay; i++) begin
      rxValid = overrun && (i >= readyDelay - 3);
      rxData  = 8'($urandom);
      if (rxValid) expOverrun = 1'b1;
      tick();
      check("blockValidOUT held", blockValid, 1'b1);
      check("blockOUT stable", blockOut, expBlock);
      check("resultReadyOUT early", resultReady, 1'b0);
    end
    rxValid = 1'b0;
    check("overrunOUT", overrunFlag, expOverrun);

    blockReady = 1'b1;
    tick();
    blockReady = 1'b0;
    check("blockValidOUT fall", blockValid, 1'b0);
    check("resultReadyOUT rise", resultReady, 1'b1);

    for (int i = 0; i < cipherLat; i++) begin
      tick();
      check("resultReadyOUT held", resultReady, 1'b1);
      check("txLoadOUT idle", txLoad, 1'b0);
    end
    resultValid = 1'b1;
    resultVec   = expResult;
    tick();
    resultValid = 1'b0;
    resultVec   = {$urandom, $urandom, $urandom, $urandom};
    check("txLoadOUT rise", txLoad, 1'b1);
    check("resultReadyOUT fall", resultReady, 1'b0);

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 20 * n) begin
      if (idx == abortAt) begin
        doReset();
        return;
      end
      check("txLoadOUT held", txLoad, 1'b1);
      check("txDataOUT", txData, rb[idx]);
      case (txMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      txReady = rdy;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    txReady = 1'b0;
    check("tx bytes sent", idx, n);
    check("txLoadOUT fall", txLoad, 1'b0);
    if (txMode == 0) check("tx back-to-back cycles", cyc, n);
    check("overrunOUT sticky", overrunFlag, expOverrun);
  endtask

  initial begin
    q8T q;
    logic [7:0] key;

    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1 checkResetValues("reset");
    end
    sel = 1'b0;
    tick();
    nReset = 1'b1;
    tick();

    // Instance A: echo of 00..0F, zero handshake wait, 2-cycle cipher.
    q = {};
    for (int k = 0; k < c_bytesA; k++) q.push_back(8'(k));
    runBlock(q, 0, 0, 1'b0, 2, 0, 8'h00, -1);
    check("block A 00..0F", blockOut, 128'h000102030405060708090a0b0c0d0e0f);

    // Random blocks, random waits and tx stalls, non-trivial cipher.
    for (int t = 0; t < 3; t++) begin
      key = 8'($urandom);
      runBlock(randBlock(c_bytesA), 0, $urandom_range(0, 3), 1'b0,
               $urandom_range(0, 4), 2, key, -1);
    end

    // Overrun: cipher stalls 10 cycles, 3 extra bytes arrive and are dropped.
    runBlock(randBlock(c_bytesA), 0, 10, 1'b1, 1, 0, 8'h5a, -1);
    runBlock(randBlock(c_bytesA), 0, 0, 1'b0, 1, 0, 8'h00, -1);

    // Timeout: 5 bytes then idle; pulse after the 20th idle cycle.
    q = randBlock(c_bytesA);
    sendBytes(q, 0, 5);
    for (int i = 1; i <= 22; i++) begin
      tick();
      check("timeoutOUT", timeoutPulse, (i == 20));
      check("byteCountOUT idle", byteCount, (i >= 20) ? 0 : 5);
    end
    runBlock(randBlock(c_bytesA), 0, 0, 1'b0, 1, 0, 8'h3c, -1);

    // A byte arriving on the cycle the timeout would fire is kept.
    q = randBlock(c_bytesA);
    sendBytes(q, 0, 5);
    for (int i = 1; i <= 19; i++) begin
      tick();
      check("timeoutOUT early", timeoutPulse, 1'b0);
    end
    runBlock(q, 5, 0, 1'b0, 1, 0, 8'hc3, -1);

    // Transmitter ready 1-of-3.
    runBlock(randBlock(c_bytesA), 0, 1, 1'b0, 2, 1, 8'h81, -1);

    // Reset in SEND after 7 bytes, then a clean block.
    runBlock(randBlock(c_bytesA), 0, 0, 1'b0, 1, 1, 8'h77, 7);
    runBlock(randBlock(c_bytesA), 0, 0, 1'b0, 2, 0, 8'h12, -1);

    // Instance B: LSB-first echo of 11,22,33,44, then random blocks.
    sel = 1'b1;
    #1;
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    runBlock(q, 0, 0, 1'b0, 2, 0, 8'h00, -1);
    check("block B 11..44", blockOut, 128'h44332211);
    for (int t = 0; t < 3; t++) begin
      key = 8'($urandom);
      runBlock(randBlock(c_bytesB), 0, $urandom_range(0, 3), 1'b0,
               $urandom_range(0, 3), 2, key, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
`default_nettype wire
